scenario_experiment_fsm: RTL and testbench
==========================================

# scenario_experiment_fsm

Single-run detonation scenario engine for the synchronization block; it sits directly upstream of the scenario multiplexer and drives one of its output-port-bus slots (detonation_signal, output_trigger, scenario_state, counter_out). It arms on a start command, waits for a synchronized external trigger, and runs a programmable delay. It then fires a detonation pulse of programmable width and repeats for a programmable number of shots. Arm-timeout is reported as a fault.

## Interface
- COUNTER_WIDTH, 32, width of delay, pulse, timeout and shot counters and of counter_out
- SYNC_STAGES, 2, flip-flop stages on the external trigger synchronizer (minimum 2)
- clock  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low, no other reset domain
- scen_start  input  1  level sampled each cycle; start/restart command
- scen_abort  input  1  synchronous abort; returns block to IDLE
- input_trigger  input  1  asynchronous external trigger (input_ports.input_trigger)
- delay_cycles  input  COUNTER_WIDTH  trigger-to-fire delay in clocks (parameters_ports)
- pulse_width  input  COUNTER_WIDTH  detonation pulse length in clocks; 0 treated as 1
- shot_count  input  COUNTER_WIDTH  shots per run; 0 treated as 1
- arm_timeout  input  COUNTER_WIDTH  max clocks waiting in ARMED; 0 = wait forever
- detonation_signal  output  1  high exactly while in FIRE
- output_trigger  output  1  one-cycle pulse on first cycle of each FIRE
- scenario_state  output  8  current state code
- counter_out  output  COUNTER_WIDTH  shots completed in current run

## Operation
- State codes: IDLE=0, ARMED=1, DELAY=2, FIRE=3, DONE=4, FAULT=5; scenario_state is the registered state.
- delay_cycles, pulse_width, shot_count, arm_timeout latched on entry to ARMED from IDLE/DONE/FAULT; changes mid-run ignored.
- IDLE: scen_start=1 -> ARMED; latch parameters; counter_out <= 0.
- ARMED: synchronized rising edge of input_trigger -> DELAY (or FIRE directly if delay_cycles=0); else if arm_timeout≠0 and wait counter reaches arm_timeout -> FAULT.
- DELAY: lasts exactly delay_cycles clocks, then FIRE.
- FIRE: lasts max(pulse_width,1) clocks; on exit counter_out increments; if counter_out+1 < max(shot_count,1) -> ARMED (parameters not re-latched, timeout counter cleared) else DONE.
- DONE, FAULT: sticky; scen_start=1 -> ARMED with fresh latch and counter_out <= 0.
- scen_abort=1 in any state -> IDLE next cycle, counter_out <= 0, outputs low; abort beats start in the same cycle.
- scen_start while ARMED/DELAY/FIRE ignored.
- Trigger edge and timeout expiry in the same cycle: trigger wins.
- Trigger edges outside ARMED are discarded (no queuing).
- Counters never wrap: internal counters compare with equality against latched values, which fit COUNTER_WIDTH.

## Timing
- Reset values: state IDLE, scenario_state=0, detonation_signal=0, output_trigger=0, counter_out=0, synchronizer and latches 0.
- All outputs registered; no combinational path from any input to any output.
- input_trigger rise to edge detect: SYNC_STAGES+1 clocks; state becomes DELAY/FIRE on the following edge.
- With delay_cycles=D≥1: first FIRE cycle is D clocks after first DELAY cycle.
- detonation_signal and output_trigger rise in the same cycle scenario_state becomes 3.
- scen_start to scenario_state=1: 1 clock.
- reset_n assertion mid-pulse drops detonation_signal immediately (asynchronously).

## Structure
- Shared package (bus_package): scenario_state_t enum (8-bit, codes above) and a constant for the default COUNTER_WIDTH.
- Sub-module trigger_sync_edge: SYNC_STAGES-deep synchronizer plus rising-edge detector with one-cycle pulse output; reused for other asynchronous inputs.
- Main module: one state register, one shared duration counter (timeout/delay/pulse), one shot counter, and a parameter latch bank.

## Test plan
- Reset: hold reset_n=0 during random inputs -> all outputs 0, scenario_state=0; release -> stays IDLE.
- Single shot: delay=10, width=4, shots=1, trigger rises 5 clocks after start -> FIRE begins 10 clocks after DELAY entry, detonation high 4 clocks, output_trigger 1 clock, DONE with counter_out=1.
- Multi-shot with delay=0: shots=3, width=0, three trigger edges -> three 1-clock pulses directly from ARMED, counter_out 1,2,3, DONE.
- Timeout: arm_timeout=20, no trigger -> FAULT (5) after 20 clocks in ARMED. Repeat with trigger edge detected exactly at expiry -> DELAY, not FAULT.
- Abort mid-FIRE with scen_start also high -> IDLE next clock, detonation low, counter_out=0.
- Parameter change during DELAY (delay 10 -> 100) and trigger during FIRE -> timing uses latched 10; extra edge ignored, counter_out unaffected.

Source files
------------

// File: rtl/bus_package.sv
// Shared types and defaults for the synchronization-block scenario engines.
package bus_package;

   localparam int DEFAULT_COUNTER_WIDTH = 32;

   typedef enum logic [7:0] {
      ST_IDLE  = 8'd0,
      ST_ARMED = 8'd1,
      ST_DELAY = 8'd2,
      ST_FIRE  = 8'd3,
      ST_DONE  = 8'd4,
      ST_FAULT = 8'd5
   } scenario_state_t;

endpackage

// File: rtl/trigger_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input followed by a registered
// rising-edge detector producing a one-cycle pulse.
module trigger_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic edge_pulse
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   // The pulse is registered so downstream logic never sees a combinational path from the pin.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         last_q     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[STAGES-2:0], async_in};
         last_q     <= sync_q[STAGES-1];
         edge_pulse <= sync_q[STAGES-1] & ~last_q;
      end
   end

endmodule

// File: rtl/scenario_experiment_fsm.sv
// Single-run detonation scenario engine: arm, wait for a synchronized trigger,
// delay, fire a programmable-width pulse, repeat for the programmed shot count.
module scenario_experiment_fsm
   import bus_package::*;
#(
   parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     scen_start,
   input  logic                     scen_abort,
   input  logic                     input_trigger,
   input  logic [COUNTER_WIDTH-1:0] delay_cycles,
   input  logic [COUNTER_WIDTH-1:0] pulse_width,
   input  logic [COUNTER_WIDTH-1:0] shot_count,
   input  logic [COUNTER_WIDTH-1:0] arm_timeout,
   output logic                     detonation_signal,
   output logic                     output_trigger,
   output logic [7:0]               scenario_state,
   output logic [COUNTER_WIDTH-1:0] counter_out
);

   scenario_state_t            state;
   logic                       trig_edge;
   logic [COUNTER_WIDTH-1:0]   dur_cnt;
   logic [COUNTER_WIDTH-1:0]   shots_done;
   logic [COUNTER_WIDTH-1:0]   shots_next;
   logic [COUNTER_WIDTH-1:0]   delay_lat;
   logic [COUNTER_WIDTH-1:0]   width_lat;
   logic [COUNTER_WIDTH-1:0]   shots_lat;
   logic [COUNTER_WIDTH-1:0]   timeout_lat;

   trigger_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_trigger_sync (
      .clock      (clock),
      .reset_n    (reset_n),
      .async_in   (input_trigger),
      .edge_pulse (trig_edge)
   );

   assign shots_next     = shots_done + COUNTER_WIDTH'(1);
   assign scenario_state = state;
   assign counter_out    = shots_done;

   // dur_cnt is the shared duration counter; it holds the 1-based index of the
   // current cycle within ARMED, DELAY or FIRE, so equality against the latched
   // limit marks the last cycle of that state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         dur_cnt           <= '0;
         shots_done        <= '0;
         delay_lat         <= '0;
         width_lat         <= '0;
         shots_lat         <= '0;
         timeout_lat       <= '0;
         detonation_signal <= 1'b0;
         output_trigger    <= 1'b0;
      end else begin
         output_trigger <= 1'b0;
         if (scen_abort) begin
            state             <= ST_IDLE;
            dur_cnt           <= '0;
            shots_done        <= '0;
            detonation_signal <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE, ST_FAULT: begin
                  if (scen_start) begin
                     state       <= ST_ARMED;
                     dur_cnt     <= COUNTER_WIDTH'(1);
                     shots_done  <= '0;
                     delay_lat   <= delay_cycles;
                     width_lat   <= (pulse_width == '0) ? COUNTER_WIDTH'(1) : pulse_width;
                     shots_lat   <= (shot_count == '0) ? COUNTER_WIDTH'(1) : shot_count;
                     timeout_lat <= arm_timeout;
                  end
               end
               ST_ARMED: begin
                  if (trig_edge) begin
                     dur_cnt <= COUNTER_WIDTH'(1);
                     if (delay_lat == '0) begin
                        state             <= ST_FIRE;
                        detonation_signal <= 1'b1;
                        output_trigger    <= 1'b1;
                     end else begin
                        state <= ST_DELAY;
                     end
                  end else if (timeout_lat != '0) begin
                     if (dur_cnt == timeout_lat) begin
                        state <= ST_FAULT;
                     end else begin
                        dur_cnt <= dur_cnt + COUNTER_WIDTH'(1);
                     end
                  end
               end
               ST_DELAY: begin
                  if (dur_cnt == delay_lat) begin
                     state             <= ST_FIRE;
                     dur_cnt           <= COUNTER_WIDTH'(1);
                     detonation_signal <= 1'b1;
                     output_trigger    <= 1'b1;
                  end else begin
                     dur_cnt <= dur_cnt + COUNTER_WIDTH'(1);
                  end
               end
               ST_FIRE: begin
                  if (dur_cnt == width_lat) begin
                     detonation_signal <= 1'b0;
                     shots_done        <= shots_next;
                     dur_cnt           <= COUNTER_WIDTH'(1);
                     state             <= (shots_next == shots_lat) ? ST_DONE : ST_ARMED;
                  end else begin
                     dur_cnt <= dur_cnt + COUNTER_WIDTH'(1);
                  end
               end
               default: begin
                  state             <= ST_IDLE;
                  dur_cnt           <= '0;
                  detonation_signal <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scenario_experiment_fsm.sv
// Directed self-checking bench for scenario_experiment_fsm with hand-computed
// cycle counts for the trigger, delay, pulse and timeout paths.
module tb_scenario_experiment_fsm;

   localparam int CW = 32;

   logic          clock;
   logic          reset_n;
   logic          scen_start;
   logic          scen_abort;
   logic          input_trigger;
   logic [CW-1:0] delay_cycles;
   logic [CW-1:0] pulse_width;
   logic [CW-1:0] shot_count;
   logic [CW-1:0] arm_timeout;
   logic          detonation_signal;
   logic          output_trigger;
   logic [7:0]    scenario_state;
   logic [CW-1:0] counter_out;

   int compared   = 0;
   int mismatched = 0;

   scenario_experiment_fsm #(
      .COUNTER_WIDTH (CW),
      .SYNC_STAGES   (2)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .scen_start        (scen_start),
      .scen_abort        (scen_abort),
      .input_trigger     (input_trigger),
      .delay_cycles      (delay_cycles),
      .pulse_width       (pulse_width),
      .shot_count        (shot_count),
      .arm_timeout       (arm_timeout),
      .detonation_signal (detonation_signal),
      .output_trigger    (output_trigger),
      .scenario_state    (scenario_state),
      .counter_out       (counter_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Steps until scenario_state equals target; returns the number of clocks taken (budget on expiry).
   task automatic wait_state(input logic [7:0] target, input int budget, output int n);
      n = 0;
      while (scenario_state !== target && n < budget) begin
         step(1);
         n++;
      end
   endtask

   task automatic set_params(input int d, input int w, input int s, input int t);
      delay_cycles = CW'(d);
      pulse_width  = CW'(w);
      shot_count   = CW'(s);
      arm_timeout  = CW'(t);
   endtask

   task automatic start_run();
      scen_start = 1'b1;
      step(1);
      scen_start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         scen_start    = 1'($urandom_range(0, 1));
         scen_abort    = 1'($urandom_range(0, 1));
         input_trigger = 1'($urandom_range(0, 1));
         delay_cycles  = $urandom;
         pulse_width   = $urandom;
         shot_count    = $urandom;
         arm_timeout   = $urandom;
         step(1);
         compared++; if (detonation_signal !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_det: got %0d, expected 0", detonation_signal); end
         compared++; if (output_trigger !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_otrig: got %0d, expected 0", output_trigger); end
         compared++; if (scenario_state !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_state: got %0d, expected 0", scenario_state); end
         compared++; if (counter_out !== '0) begin mismatched++; $display("[TB] FAIL reset_counter: got %0d, expected 0", counter_out); end
      end
      scen_start    = 1'b0;
      scen_abort    = 1'b0;
      input_trigger = 1'b0;
      set_params(0, 0, 0, 0);
      step(1);
      reset_n = 1'b1;
      step(3);
      compared++; if (scenario_state !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_release_idle: got %0d, expected 0", scenario_state); end
   endtask

   task automatic test_single_shot();
      int n;
      set_params(10, 4, 1, 0);
      input_trigger = 1'b0;
      step(3);
      start_run();
      compared++; if (scenario_state !== 8'd1) begin mismatched++; $display("[TB] FAIL single_armed: got %0d, expected 1", scenario_state); end
      step(4);
      input_trigger = 1'b1;
      wait_state(8'd2, 20, n);
      compared++; if (n !== 4) begin mismatched++; $display("[TB] FAIL single_trig_latency: got %0d, expected 4", n); end
      wait_state(8'd3, 40, n);
      compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL single_delay_len: got %0d, expected 10", n); end
      compared++; if (detonation_signal !== 1'b1) begin mismatched++; $display("[TB] FAIL single_det_rise: got %0d, expected 1", detonation_signal); end
      compared++; if (output_trigger !== 1'b1) begin mismatched++; $display("[TB] FAIL single_otrig_rise: got %0d, expected 1", output_trigger); end
      step(1);
      compared++; if (output_trigger !== 1'b0) begin mismatched++; $display("[TB] FAIL single_otrig_one_cycle: got %0d, expected 0", output_trigger); end
      compared++; if (detonation_signal !== 1'b1) begin mismatched++; $display("[TB] FAIL single_det_hold: got %0d, expected 1", detonation_signal); end
      wait_state(8'd4, 20, n);
      compared++; if (n !== 3) begin mismatched++; $display("[TB] FAIL single_pulse_len: got %0d, expected 3", n); end
      compared++; if (detonation_signal !== 1'b0) begin mismatched++; $display("[TB] FAIL single_det_fall: got %0d, expected 0", detonation_signal); end
      compared++; if (counter_out !== CW'(1)) begin mismatched++; $display("[TB] FAIL single_counter: got %0d, expected 1", counter_out); end
   endtask

   task automatic test_multi_shot();
      int n;
      set_params(0, 0, 3, 0);
      start_run();
      compared++; if (scenario_state !== 8'd1) begin mismatched++; $display("[TB] FAIL multi_armed: got %0d, expected 1", scenario_state); end
      compared++; if (counter_out !== '0) begin mismatched++; $display("[TB] FAIL multi_counter_clear: got %0d, expected 0", counter_out); end
      for (int shot = 1; shot <= 3; shot++) begin
         input_trigger = 1'b0;
         step(3);
         input_trigger = 1'b1;
         wait_state(8'd3, 20, n);
         compared++; if (n !== 4) begin mismatched++; $display("[TB] FAIL multi_direct_fire shot %0d: got %0d, expected 4", shot, n); end
         compared++; if ({detonation_signal, output_trigger} !== 2'b11) begin mismatched++; $display("[TB] FAIL multi_outputs shot %0d: got %0d, expected 3", shot, {detonation_signal, output_trigger}); end
         step(1);
         compared++; if (counter_out !== CW'(shot)) begin mismatched++; $display("[TB] FAIL multi_counter shot %0d: got %0d, expected %0d", shot, counter_out, shot); end
         compared++; if (scenario_state !== ((shot < 3) ? 8'd1 : 8'd4)) begin mismatched++; $display("[TB] FAIL multi_next_state shot %0d: got %0d, expected %0d", shot, scenario_state, (shot < 3) ? 1 : 4); end
         compared++; if (detonation_signal !== 1'b0) begin mismatched++; $display("[TB] FAIL multi_det_fall shot %0d: got %0d, expected 0", shot, detonation_signal); end
      end
   endtask

   task automatic test_timeout();
      int n;
      set_params(5, 1, 1, 20);
      input_trigger = 1'b0;
      step(3);
      start_run();
      compared++; if (scenario_state !== 8'd1) begin mismatched++; $display("[TB] FAIL timeout_armed: got %0d, expected 1", scenario_state); end
      wait_state(8'd5, 40, n);
      compared++; if (n !== 20) begin mismatched++; $display("[TB] FAIL timeout_len: got %0d, expected 20", n); end
      start_run();
      compared++; if (scenario_state !== 8'd1) begin mismatched++; $display("[TB] FAIL timeout_rearm_from_fault: got %0d, expected 1", scenario_state); end
      step(16);
      input_trigger = 1'b1;
      step(3);
      compared++; if (scenario_state !== 8'd1) begin mismatched++; $display("[TB] FAIL timeout_last_armed: got %0d, expected 1", scenario_state); end
      step(1);
      compared++; if (scenario_state !== 8'd2) begin mismatched++; $display("[TB] FAIL timeout_trigger_wins: got %0d, expected 2", scenario_state); end
      scen_abort = 1'b1;
      step(1);
      scen_abort = 1'b0;
      compared++; if (scenario_state !== 8'd0) begin mismatched++; $display("[TB] FAIL timeout_abort_idle: got %0d, expected 0", scenario_state); end
   endtask

   task automatic test_abort();
      int n;
      set_params(0, 5, 3, 0);
      input_trigger = 1'b0;
      step(3);
      start_run();
      input_trigger = 1'b1;
      wait_state(8'd3, 20, n);
      compared++; if (n !== 4) begin mismatched++; $display("[TB] FAIL abort_first_fire: got %0d, expected 4", n); end
      wait_state(8'd1, 20, n);
      compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL abort_first_width: got %0d, expected 5", n); end
      compared++; if (counter_out !== CW'(1)) begin mismatched++; $display("[TB] FAIL abort_first_counter: got %0d, expected 1", counter_out); end
      input_trigger = 1'b0;
      step(3);
      input_trigger = 1'b1;
      wait_state(8'd3, 20, n);
      step(2);
      scen_abort = 1'b1;
      scen_start = 1'b1;
      step(1);
      compared++; if (scenario_state !== 8'd0) begin mismatched++; $display("[TB] FAIL abort_state: got %0d, expected 0", scenario_state); end
      compared++; if (detonation_signal !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_det: got %0d, expected 0", detonation_signal); end
      compared++; if (output_trigger !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_otrig: got %0d, expected 0", output_trigger); end
      compared++; if (counter_out !== '0) begin mismatched++; $display("[TB] FAIL abort_counter: got %0d, expected 0", counter_out); end
      scen_abort = 1'b0;
      scen_start = 1'b0;
      step(2);
      compared++; if (scenario_state !== 8'd0) begin mismatched++; $display("[TB] FAIL abort_stays_idle: got %0d, expected 0", scenario_state); end
   endtask

   task automatic test_param_change();
      int n;
      set_params(10, 8, 2, 0);
      input_trigger = 1'b0;
      step(3);
      start_run();
      input_trigger = 1'b1;
      wait_state(8'd2, 20, n);
      compared++; if (n !== 4) begin mismatched++; $display("[TB] FAIL param_trig_latency: got %0d, expected 4", n); end
      set_params(100, 1, 1, 3);
      input_trigger = 1'b0;
      wait_state(8'd3, 150, n);
      compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL param_latched_delay: got %0d, expected 10", n); end
      input_trigger = 1'b1;
      wait_state(8'd1, 30, n);
      compared++; if (n !== 8) begin mismatched++; $display("[TB] FAIL param_latched_width: got %0d, expected 8", n); end
      compared++; if (counter_out !== CW'(1)) begin mismatched++; $display("[TB] FAIL param_counter_after_fire: got %0d, expected 1", counter_out); end
      step(5);
      compared++; if (scenario_state !== 8'd1) begin mismatched++; $display("[TB] FAIL param_edge_discarded: got %0d, expected 1", scenario_state); end
      compared++; if (counter_out !== CW'(1)) begin mismatched++; $display("[TB] FAIL param_counter_stable: got %0d, expected 1", counter_out); end
      input_trigger = 1'b0;
      step(3);
      input_trigger = 1'b1;
      wait_state(8'd2, 20, n);
      wait_state(8'd3, 150, n);
      compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL param_second_delay: got %0d, expected 10", n); end
      wait_state(8'd4, 30, n);
      compared++; if (n !== 8) begin mismatched++; $display("[TB] FAIL param_second_width: got %0d, expected 8", n); end
      compared++; if (counter_out !== CW'(2)) begin mismatched++; $display("[TB] FAIL param_final_counter: got %0d, expected 2", counter_out); end
   endtask

   task automatic test_async_reset();
      int n;
      set_params(0, 10, 1, 0);
      input_trigger = 1'b0;
      step(3);
      start_run();
      input_trigger = 1'b1;
      wait_state(8'd3, 20, n);
      step(2);
      compared++; if (detonation_signal !== 1'b1) begin mismatched++; $display("[TB] FAIL areset_mid_pulse: got %0d, expected 1", detonation_signal); end
      #2;
      reset_n = 1'b0;
      #1;
      compared++; if (detonation_signal !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_det_drop: got %0d, expected 0", detonation_signal); end
      compared++; if (scenario_state !== 8'd0) begin mismatched++; $display("[TB] FAIL areset_state: got %0d, expected 0", scenario_state); end
      #1;
      reset_n = 1'b1;
      step(2);
      compared++; if (scenario_state !== 8'd0) begin mismatched++; $display("[TB] FAIL areset_idle_after: got %0d, expected 0", scenario_state); end
      compared++; if (counter_out !== '0) begin mismatched++; $display("[TB] FAIL areset_counter: got %0d, expected 0", counter_out); end
   endtask

   initial begin
      reset_n       = 1'b0;
      scen_start    = 1'b0;
      scen_abort    = 1'b0;
      input_trigger = 1'b0;
      set_params(0, 0, 0, 0);
      test_reset();
      test_single_shot();
      test_multi_shot();
      test_timeout();
      test_abort();
      test_param_change();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
